// File: rtl/hist_pkg.sv
// Shared definitions for the pulse-width histogram path: FSM encoding and
// small width helpers, also used by the UART readout logic.
package hist_pkg;

  localparam int HIST_MAX_CH = 8;

  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_UPD_RD   = 3'd2,
    ST_UPD_WR   = 3'd3,
    ST_HOST_RD  = 3'd4,
    ST_HOST_RSP = 3'd5
  } hist_state_t;

  // Channel-select width; never below one bit so a single channel still has a field
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pwc_hist_multi_if.sv
// Host-side port bundle of the histogram engine: clear control, bin read
// port and the drop counter.
interface pwc_hist_multi_if
  import hist_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int DROP_WIDTH = 16
);
  localparam int CH_W = clog2_min1(NUM_CH);

  logic                  clear_req;
  logic                  busy;
  logic                  clear_done;
  logic                  rd_req;
  logic [CH_W-1:0]       rd_ch;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DROP_WIDTH-1:0] drop_count;

  modport master (
    output clear_req, rd_req, rd_ch, rd_addr,
    input  busy, clear_done, rd_valid, rd_data, drop_count
  );

  modport slave (
    input  clear_req, rd_req, rd_ch, rd_addr,
    output busy, clear_done, rd_valid, rd_data, drop_count
  );

endinterface

// File: rtl/pwc_hist_multi_channel.sv
// One pulse channel: synchronizer, edge detect, saturating width counter,
// bin mapping and a one-deep pending slot with a drop strobe.
module pwc_channel
  import hist_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 16,
  parameter int BIN_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  pulse_in,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  grant,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_bin,
  output logic                  drop
);

  localparam logic [31:0] MAX_BIN = 32'((1 << ADDR_WIDTH) - 1);

  logic                  sync1, sync2, sync3;
  logic                  armed;
  logic [CNT_WIDTH-1:0]  count;
  logic                  rise, fall, event_valid, slot_busy;
  logic [31:0]           shifted;
  logic [ADDR_WIDTH-1:0] bin;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  // Only a rising edge seen while enabled arms the counter, so a pulse
  // already high when enable rises is never measured.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      armed <= 1'b0;
      count <= '0;
    end else if (flush || !enable) begin
      armed <= 1'b0;
      count <= '0;
    end else if (rise) begin
      armed <= 1'b1;
      count <= CNT_WIDTH'(1);
    end else if (armed && sync2) begin
      count <= CNT_WIDTH'(sat_inc(32'(count), CNT_WIDTH));
    end else if (fall) begin
      armed <= 1'b0;
    end
  end

  assign event_valid = armed & fall & enable & ~flush;
  assign shifted     = 32'(count) >> BIN_SHIFT;
  assign bin         = (shifted > MAX_BIN) ? MAX_BIN[ADDR_WIDTH-1:0] : shifted[ADDR_WIDTH-1:0];

  // A grant in the same cycle frees the slot, so a refill then is not a drop
  assign slot_busy = pend_valid & ~grant;
  assign drop      = event_valid & slot_busy;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pend_valid <= 1'b0;
      pend_bin   <= '0;
    end else if (flush) begin
      pend_valid <= 1'b0;
    end else if (event_valid && !slot_busy) begin
      pend_valid <= 1'b1;
      pend_bin   <= bin;
    end else if (grant) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pwc_hist_multi.sv
// Multi-channel pulse-width histogram: per-channel width counters feed a
// round-robin arbiter and a serialized read-modify-write bin memory.
module pwc_hist_multi
  import hist_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int BIN_SHIFT  = 0,
  parameter int DROP_WIDTH = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic              enable,
  pwc_hist_multi_if.slave   host
);

  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int DEPTH  = NUM_CH * (1 << ADDR_WIDTH);
  localparam int MEM_AW = CH_W + ADDR_WIDTH;
  localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);

  hist_state_t state, next_state;

  logic [NUM_CH-1:0]     pend_valid;
  logic [ADDR_WIDTH-1:0] pend_bin [NUM_CH];
  logic [NUM_CH-1:0]     drop;
  logic [NUM_CH-1:0]     grant;
  logic                  sweep;

  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       sel_ch;
  logic                  any_pend;
  int                    arb_idx;

  logic [MEM_AW-1:0]     clr_addr;
  logic [MEM_AW-1:0]     upd_addr;
  logic                  clear_pend;
  logic                  host_oob;
  logic [31:0]           rd_ch_ext;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rsp_value;
  logic [DROP_WIDTH-1:0] drop_count;
  logic [DROP_WIDTH-1:0] drop_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  mem_we, mem_re;

  assign sweep = (state == ST_CLEAR);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwc_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .BIN_SHIFT  (BIN_SHIFT)
    ) u_ch (
      .clk        (clk),
      .areset_n   (areset_n),
      .pulse_in   (pulse_in[gi]),
      .enable     (enable),
      .flush      (sweep),
      .grant      (grant[gi]),
      .pend_valid (pend_valid[gi]),
      .pend_bin   (pend_bin[gi]),
      .drop       (drop[gi])
    );
  end

  // Round-robin search starts at the channel after the last one granted
  always_comb begin
    any_pend = 1'b0;
    sel_ch   = '0;
    arb_idx  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!any_pend && pend_valid[arb_idx]) begin
        any_pend = 1'b1;
        sel_ch   = CH_W'(arb_idx);
      end
    end
  end

  always_comb begin
    drop_next = drop_count;
    for (int k = 0; k < NUM_CH; k++) begin
      if (drop[k]) drop_next = DROP_WIDTH'(sat_inc(32'(drop_next), DROP_WIDTH));
    end
  end

  assign rd_ch_ext = 32'(host.rd_ch);
  assign rsp_value = host_oob ? '0 : mem_rdata;

  always_comb begin
    next_state = state;
    grant      = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        if (clr_addr == LAST_ADDR) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (host.clear_req || clear_pend) begin
          next_state = ST_CLEAR;
        end else if (host.rd_req) begin
          next_state = ST_HOST_RD;
        end else if (any_pend) begin
          grant[sel_ch] = 1'b1;
          next_state    = ST_UPD_RD;
        end
      end
      ST_UPD_RD: begin
        mem_re     = 1'b1;
        mem_addr   = upd_addr;
        next_state = ST_UPD_WR;
      end
      ST_UPD_WR: begin
        mem_we     = 1'b1;
        mem_addr   = upd_addr;
        mem_wdata  = DATA_WIDTH'(sat_inc(32'(mem_rdata), DATA_WIDTH));
        next_state = ST_IDLE;
      end
      ST_HOST_RD: begin
        mem_re     = (rd_ch_ext < 32'(NUM_CH));
        mem_addr   = {host.rd_ch, host.rd_addr};
        next_state = ST_HOST_RSP;
      end
      ST_HOST_RSP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_CLEAR;
      end
    endcase
  end

  // Memory is never reset; the sweep that follows reset zeroes it
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      upd_addr   <= '0;
      rr_ptr     <= '0;
      clear_pend <= 1'b0;
      host_oob   <= 1'b0;
      rd_data_q  <= '0;
      drop_count <= '0;
    end else begin
      state    <= next_state;
      clr_addr <= sweep ? clr_addr + 1'b1 : '0;
      if (state == ST_IDLE && next_state == ST_UPD_RD) begin
        upd_addr <= {sel_ch, pend_bin[sel_ch]};
        rr_ptr   <= (int'(sel_ch) == NUM_CH - 1) ? '0 : sel_ch + 1'b1;
      end
      if (state == ST_IDLE) clear_pend <= 1'b0;
      else if (host.clear_req) clear_pend <= 1'b1;
      if (state == ST_HOST_RD) host_oob <= (rd_ch_ext >= 32'(NUM_CH));
      if (state == ST_HOST_RSP) rd_data_q <= rsp_value;
      drop_count <= sweep ? '0 : drop_next;
    end
  end

  assign host.busy       = sweep;
  assign host.clear_done = sweep && (clr_addr == LAST_ADDR);
  assign host.rd_valid   = (state == ST_HOST_RSP);
  assign host.rd_data    = (state == ST_HOST_RSP) ? rsp_value : rd_data_q;
  assign host.drop_count = drop_count;

endmodule

// File: tb/tb_pwc_hist_multi.sv
// Directed bench: three histogram instances share clock, reset and pulse
// inputs; A is the baseline, B uses BIN_SHIFT=2 with 3 channels, C has 4-bit bins.
module tb_pwc_hist_multi;

  logic       clk;
  logic       areset_n;
  logic       enable;
  logic [1:0] pulse;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [15:0] d;

  pwc_hist_multi_if #(.NUM_CH(2), .ADDR_WIDTH(4), .DATA_WIDTH(16), .DROP_WIDTH(16)) hA ();
  pwc_hist_multi_if #(.NUM_CH(3), .ADDR_WIDTH(4), .DATA_WIDTH(16), .DROP_WIDTH(16)) hB ();
  pwc_hist_multi_if #(.NUM_CH(2), .ADDR_WIDTH(4), .DATA_WIDTH(4),  .DROP_WIDTH(16)) hC ();

  pwc_hist_multi #(.NUM_CH(2), .ADDR_WIDTH(4), .DATA_WIDTH(16), .CNT_WIDTH(16),
                   .BIN_SHIFT(0), .DROP_WIDTH(16)) dut_a (
    .clk(clk), .areset_n(areset_n), .pulse_in(pulse), .enable(enable), .host(hA));

  pwc_hist_multi #(.NUM_CH(3), .ADDR_WIDTH(4), .DATA_WIDTH(16), .CNT_WIDTH(16),
                   .BIN_SHIFT(2), .DROP_WIDTH(16)) dut_b (
    .clk(clk), .areset_n(areset_n), .pulse_in({1'b0, pulse}), .enable(enable), .host(hB));

  pwc_hist_multi #(.NUM_CH(2), .ADDR_WIDTH(4), .DATA_WIDTH(4), .CNT_WIDTH(16),
                   .BIN_SHIFT(0), .DROP_WIDTH(16)) dut_c (
    .clk(clk), .areset_n(areset_n), .pulse_in(pulse), .enable(enable), .host(hC));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_rd(input int sel, input logic req, input int ch, input int addr);
    case (sel)
      0: begin hA.rd_req = req; hA.rd_ch = 1'(ch); hA.rd_addr = 4'(addr); end
      1: begin hB.rd_req = req; hB.rd_ch = 2'(ch); hB.rd_addr = 4'(addr); end
      default: begin hC.rd_req = req; hC.rd_ch = 1'(ch); hC.rd_addr = 4'(addr); end
    endcase
  endtask

  // Called at a negedge; raises rd_req immediately and waits for rd_valid
  task automatic read_bin(input int sel, input int ch, input int addr,
                          output logic [15:0] data, output int latency);
    bit got;
    got = 0;
    data = 'x;
    latency = 0;
    drive_rd(sel, 1'b1, ch, addr);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      latency++;
      case (sel)
        0: if (hA.rd_valid) begin got = 1; data = hA.rd_data; end
        1: if (hB.rd_valid) begin got = 1; data = hB.rd_data; end
        default: if (hC.rd_valid) begin got = 1; data = {12'd0, hC.rd_data}; end
      endcase
    end
    drive_rd(sel, 1'b0, ch, addr);
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL read_timeout dut=%0d ch=%0d addr=%0d got=no_rd_valid exp=rd_valid", sel, ch, addr);
    end
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 500; n++) begin
      if (!hA.busy && !hB.busy && !hC.busy) break;
      @(negedge clk);
    end
    if (n == 500) begin
      checks++; errors++;
      $display("[TB] FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic pulse_ch(input int ch, input int width);
    @(negedge clk);
    pulse[ch] = 1'b1;
    repeat (width) @(negedge clk);
    pulse[ch] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    areset_n = 1'b0;
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
  endtask

  task automatic test_reset();
    int busy_cycles, done_pulses;
    areset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hA.busy, hA.clear_done, hA.rd_valid, hA.rd_data, hA.drop_count} !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b/%b/%b/%0d/%0d exp=1/0/0/0/0",
               hA.busy, hA.clear_done, hA.rd_valid, hA.rd_data, hA.drop_count);
    end
    areset_n = 1'b1;
    busy_cycles = 0;
    done_pulses = 0;
    for (int n = 0; n < 200; n++) begin
      if (!hA.busy) break;
      busy_cycles++;
      if (hA.clear_done) done_pulses++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 32) begin
      errors++; $display("[TB] FAIL sweep_length got=%0d exp=32", busy_cycles);
    end
    checks++;
    if (done_pulses != 1) begin
      errors++; $display("[TB] FAIL clear_done_pulses got=%0d exp=1", done_pulses);
    end
    wait_idle();
    for (int ch = 0; ch < 2; ch++) begin
      for (int b = 0; b < 16; b++) begin
        read_bin(0, ch, b, d, lat);
        checks++;
        if (d !== 16'd0) begin
          errors++; $display("[TB] FAIL reset_bin ch=%0d bin=%0d got=%0d exp=0", ch, b, d);
        end
      end
    end
  endtask

  task automatic test_single_pulse();
    pulse_ch(0, 5);
    repeat (12) @(negedge clk);
    read_bin(0, 0, 5, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL a_ch0_bin5 got=%0d exp=1", d); end
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL read_latency got=%0d exp=2", lat); end
    read_bin(0, 1, 5, d, lat);
    checks++;
    if (d !== 16'd0) begin errors++; $display("[TB] FAIL a_ch1_bin5 got=%0d exp=0", d); end
    checks++;
    if (hA.drop_count !== 16'd0) begin errors++; $display("[TB] FAIL a_drop_single got=%0d exp=0", hA.drop_count); end
    read_bin(1, 0, 1, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL b_ch0_bin1_shift got=%0d exp=1", d); end
  endtask

  task automatic test_overflow_and_shift();
    pulse_ch(1, 40);
    repeat (12) @(negedge clk);
    read_bin(0, 1, 15, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL a_ch1_overflow_bin got=%0d exp=1", d); end
    read_bin(1, 1, 10, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL b_ch1_bin10 got=%0d exp=1", d); end
    pulse_ch(0, 9);
    repeat (12) @(negedge clk);
    read_bin(1, 0, 2, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL b_ch0_bin2 got=%0d exp=1", d); end
    read_bin(0, 0, 9, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL a_ch0_bin9 got=%0d exp=1", d); end
    read_bin(1, 3, 2, d, lat);
    checks++;
    if (d !== 16'd0) begin errors++; $display("[TB] FAIL b_out_of_range_ch got=%0d exp=0", d); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    wait_idle();
    @(negedge clk);
    pulse = 2'b11;
    repeat (3) @(negedge clk);
    pulse = 2'b00;
    // Read lands between the two updates: ch0 done, ch1 still waiting
    repeat (5) @(negedge clk);
    read_bin(0, 0, 3, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL rr_ch0_first got=%0d exp=1", d); end
    repeat (8) @(negedge clk);
    read_bin(0, 1, 3, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL simul_ch1_bin3 got=%0d exp=1", d); end
    checks++;
    if (hA.drop_count !== 16'd0) begin errors++; $display("[TB] FAIL simul_drop got=%0d exp=0", hA.drop_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      pulse[0] = 1'b1;
      @(negedge clk);
      pulse[0] = 1'b0;
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    read_bin(0, 0, 1, d, lat);
    checks++;
    if (32'(d) + 32'(hA.drop_count) != 32'd10) begin
      errors++; $display("[TB] FAIL b2b_conservation got=%0d+%0d exp_sum=10", d, hA.drop_count);
    end
    checks++;
    if (hA.drop_count == 16'd0) begin errors++; $display("[TB] FAIL b2b_drops got=0 exp=nonzero"); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      pulse_ch(0, 3);
      repeat (8) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    read_bin(2, 0, 3, d, lat);
    checks++;
    if (d !== 16'd15) begin errors++; $display("[TB] FAIL c_saturated_bin got=%0d exp=15", d); end
    read_bin(0, 0, 3, d, lat);
    checks++;
    if (d !== 16'd21) begin errors++; $display("[TB] FAIL a_wide_bin got=%0d exp=21", d); end
  endtask

  task automatic test_clear_during_rmw();
    int n, done_pulses;
    checks++;
    if (hA.drop_count == 16'd0) begin errors++; $display("[TB] FAIL pre_clear_drops got=0 exp=nonzero"); end
    pulse_ch(0, 7);
    repeat (4) @(negedge clk);
    hA.clear_req = 1'b1;
    @(negedge clk);
    hA.clear_req = 1'b0;
    checks++;
    if (hA.busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_deferred got=%b exp=0", hA.busy); end
    for (n = 0; n < 20; n++) begin
      if (hA.busy) break;
      @(negedge clk);
    end
    checks++;
    if (n == 20) begin errors++; $display("[TB] FAIL clear_start got=idle exp=busy"); end
    pulse_ch(1, 6);
    done_pulses = 0;
    for (n = 0; n < 100; n++) begin
      if (!hA.busy) break;
      if (hA.clear_done) done_pulses++;
      @(negedge clk);
    end
    checks++;
    if (done_pulses != 1) begin errors++; $display("[TB] FAIL clear_done_after_req got=%0d exp=1", done_pulses); end
    repeat (12) @(negedge clk);
    checks++;
    if (hA.drop_count !== 16'd0) begin errors++; $display("[TB] FAIL drop_after_clear got=%0d exp=0", hA.drop_count); end
    for (int ch = 0; ch < 2; ch++) begin
      for (int b = 0; b < 16; b++) begin
        read_bin(0, ch, b, d, lat);
        checks++;
        if (d !== 16'd0) begin
          errors++; $display("[TB] FAIL cleared_bin ch=%0d bin=%0d got=%0d exp=0", ch, b, d);
        end
      end
    end
    read_bin(2, 0, 7, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL c_ch0_bin7 got=%0d exp=1", d); end
    read_bin(2, 1, 6, d, lat);
    checks++;
    if (d !== 16'd1) begin errors++; $display("[TB] FAIL c_ch1_bin6 got=%0d exp=1", d); end
  endtask

  initial begin
    clk      = 1'b0;
    areset_n = 1'b0;
    enable   = 1'b1;
    pulse    = 2'b00;
    hA.clear_req = 1'b0; hA.rd_req = 1'b0; hA.rd_ch = '0; hA.rd_addr = '0;
    hB.clear_req = 1'b0; hB.rd_req = 1'b0; hB.rd_ch = '0; hB.rd_addr = '0;
    hC.clear_req = 1'b0; hC.rd_req = 1'b0; hC.rd_ch = '0; hC.rd_addr = '0;
    @(negedge clk);
    test_reset();
    test_single_pulse();
    test_overflow_and_shift();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    test_clear_during_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
